// File: rtl/ltc2624_pkg.sv
// LTC2624 responder shared definitions:
// command nibbles, frame fields, FSM states.
package ltc2624_pkg;

  localparam logic [3:0] CMD_WRITE            = 4'b0000;
  localparam logic [3:0] CMD_UPDATE           = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'b0010;
  localparam logic [3:0] CMD_WRITE_UPDATE     = 4'b0011;
  localparam logic [3:0] CMD_NOP              = 4'b1111;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int CMD_LSB  = 20;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  // One-hot channel mask for an address nibble
  function automatic logic [3:0] addr_sel(
    input logic [3:0] addr
  );
    logic [3:0] sel;
    sel = 4'b0000;
    unique case (1'b1)
      (addr == ADDR_ALL): sel = 4'b1111;
      (addr < 4'd4):      sel = 4'b0001 << addr[1:0];
      default:            sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ltc2624_spi_responder_if.sv
// SPI pin bundle between the DAC adapter
// (master) and the LTC2624 responder (slave).
interface ltc2624_spi_responder_if;

  logic SPI_SCK;
  logic SPI_MOSI;
  logic SPI_MISO;
  logic DAC_CS;
  logic DAC_CLR;

  modport master (
    output SPI_SCK,
    output SPI_MOSI,
    output DAC_CS,
    output DAC_CLR,
    input  SPI_MISO
  );

  modport slave (
    input  SPI_SCK,
    input  SPI_MOSI,
    input  DAC_CS,
    input  DAC_CLR,
    output SPI_MISO
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one async pin
// with rise/fall detection on the last stage.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // Shift the pin through the chain; delay flop trails the last stage
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // Chain registers, reset to the pin's idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~dly_q;
  assign fall = ~dout & dly_q;

endmodule

// File: rtl/ltc2624_spi_responder.sv
// LTC2624 quad DAC SPI slave model: decodes
// 32-bit frames, echoes the previous frame.
module ltc2624_spi_responder
  import ltc2624_pkg::*;
#(
  parameter int FRAME_BITS  = 32,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  ltc2624_spi_responder_if.slave spi,
  output logic [DATA_BITS-1:0] OUT_A,
  output logic [DATA_BITS-1:0] OUT_B,
  output logic [DATA_BITS-1:0] OUT_C,
  output logic [DATA_BITS-1:0] OUT_D,
  output logic                 FRAME_VALID,
  output logic                 FRAME_ERROR,
  output logic [3:0]           LAST_CMD,
  output logic [3:0]           LAST_ADDR
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic clr_n, clr_rise, clr_fall;
  logic unused_sync;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)
  ) u_sck (
    .clk(CLOCK), .rst_n(RESET), .din(spi.SPI_SCK),
    .dout(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)
  ) u_mosi (
    .clk(CLOCK), .rst_n(RESET), .din(spi.SPI_MOSI),
    .dout(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)
  ) u_cs (
    .clk(CLOCK), .rst_n(RESET), .din(spi.DAC_CS),
    .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)
  ) u_clr (
    .clk(CLOCK), .rst_n(RESET), .din(spi.DAC_CLR),
    .dout(clr_n), .rise(clr_rise), .fall(clr_fall)
  );

  assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall,
                         cs_lvl, clr_rise, clr_fall};

  state_e state_q, state_d;

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  miso_q, miso_d;

  logic [3:0][DATA_BITS-1:0] in_q, in_d;
  logic [3:0][DATA_BITS-1:0] out_q, out_d;
  logic [3:0][DATA_BITS-1:0] wr_in;

  logic [3:0] last_cmd_q, last_cmd_d;
  logic [3:0] last_addr_q, last_addr_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  logic [3:0]           f_cmd, f_addr, f_sel;
  logic [DATA_BITS-1:0] f_data;

  assign f_cmd  = sr_q[CMD_LSB +: 4];
  assign f_addr = sr_q[ADDR_LSB +: 4];
  assign f_data = sr_q[DATA_LSB +: DATA_BITS];
  assign f_sel  = addr_sel(f_addr);

  // State register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: CS frames the SHIFT phase, COMMIT lasts one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT:  if (cs_rise) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Shift path: capture MOSI on SCK rise, present echo on SCK fall
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    miso_d = miso_q;
    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          cnt_d  = '0;
          miso_d = sr_q[FRAME_BITS-1];
        end
      end
      ST_SHIFT: begin
        if (sck_rise) begin
          sr_d = {sr_q[FRAME_BITS-2:0], mosi_lvl};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
        if (sck_fall) miso_d = sr_q[FRAME_BITS-1];
      end
      default: miso_d = 1'b0;
    endcase
  end

  // Commit decode; a held clear overrides any register write
  always_comb begin
    in_d        = in_q;
    out_d       = out_q;
    last_cmd_d  = last_cmd_q;
    last_addr_d = last_addr_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    wr_in       = in_q;
    for (int i = 0; i < 4; i++) begin
      if (f_sel[i]) wr_in[i] = f_data;
    end
    if (state_q == ST_COMMIT) begin
      if (cnt_q == CNT_FULL) begin
        valid_d     = 1'b1;
        last_cmd_d  = f_cmd;
        last_addr_d = f_addr;
        unique case (f_cmd)
          CMD_WRITE: in_d = wr_in;
          CMD_UPDATE: begin
            for (int i = 0; i < 4; i++) begin
              if (f_sel[i]) out_d[i] = in_q[i];
            end
          end
          CMD_WRITE_UPDATE_ALL: begin
            in_d  = wr_in;
            out_d = wr_in;
          end
          CMD_WRITE_UPDATE: begin
            in_d = wr_in;
            for (int i = 0; i < 4; i++) begin
              if (f_sel[i]) out_d[i] = f_data;
            end
          end
          CMD_NOP: ;
          default: ;
        endcase
      end else begin
        error_d = 1'b1;
      end
    end
    if (!clr_n) begin
      in_d  = '0;
      out_d = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      in_q        <= '0;
      out_q       <= '0;
      last_cmd_q  <= '0;
      last_addr_q <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      in_q        <= in_d;
      out_q       <= out_d;
      last_cmd_q  <= last_cmd_d;
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign spi.SPI_MISO = miso_q;
  assign OUT_A        = out_q[0];
  assign OUT_B        = out_q[1];
  assign OUT_C        = out_q[2];
  assign OUT_D        = out_q[3];
  assign FRAME_VALID  = valid_q;
  assign FRAME_ERROR  = error_q;
  assign LAST_CMD     = last_cmd_q;
  assign LAST_ADDR    = last_addr_q;

endmodule

// File: tb/tb_ltc2624_spi_responder.sv
// Directed bench for the LTC2624 responder:
// frame table plus reset/clear corner cases.
module tb_ltc2624_spi_responder;

  logic        CLOCK;
  logic        RESET;
  logic [11:0] OUT_A, OUT_B, OUT_C, OUT_D;
  logic        FRAME_VALID, FRAME_ERROR;
  logic [3:0]  LAST_CMD, LAST_ADDR;

  ltc2624_spi_responder_if spi_if ();

  ltc2624_spi_responder dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .spi(spi_if),
    .OUT_A(OUT_A),
    .OUT_B(OUT_B),
    .OUT_C(OUT_C),
    .OUT_D(OUT_D),
    .FRAME_VALID(FRAME_VALID),
    .FRAME_ERROR(FRAME_ERROR),
    .LAST_CMD(LAST_CMD),
    .LAST_ADDR(LAST_ADDR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    bit          clr;
    bit          exp_valid;
    logic [3:0]  exp_cmd;
    logic [3:0]  exp_addr;
    logic [47:0] exp_out;
    bit          chk_echo;
    logic [31:0] exp_echo;
  } vec_t;

  vec_t        vecs [12];
  int          n_pass;
  int          n_total;
  logic [31:0] miso_word;
  int          v_cnt;
  int          e_cnt;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic send_bit(input logic b);
    spi_if.SPI_MOSI = b;
    wait_clk(8);
    miso_word = {miso_word[30:0], spi_if.SPI_MISO};
    spi_if.SPI_SCK = 1'b1;
    wait_clk(8);
    spi_if.SPI_SCK = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] word,
                      input int nbits,
                      input bit clr);
    miso_word = '0;
    v_cnt = 0;
    e_cnt = 0;
    @(negedge CLOCK);
    spi_if.DAC_CS = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++)
      send_bit(i < 32 ? word[31 - i] : 1'b0);
    wait_clk(8);
    spi_if.DAC_CS = 1'b1;
    if (clr) spi_if.DAC_CLR = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLOCK);
      if (k == 1) spi_if.DAC_CLR = 1'b1;
      v_cnt += int'(FRAME_VALID);
      e_cnt += int'(FRAME_ERROR);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, 64'({OUT_A, OUT_B, OUT_C, OUT_D}), 64'd0);
    chk({tag, "_last_cmd"}, 64'(LAST_CMD), 64'd0);
    chk({tag, "_last_addr"}, 64'(LAST_ADDR), 64'd0);
    chk({tag, "_miso"}, 64'(spi_if.SPI_MISO), 64'd0);
    chk({tag, "_valid"}, 64'(FRAME_VALID), 64'd0);
    chk({tag, "_error"}, 64'(FRAME_ERROR), 64'd0);
  endtask

  task automatic mid_reset();
    @(negedge CLOCK);
    spi_if.DAC_CS = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    @(negedge CLOCK);
    RESET = 1'b0;
    spi_if.DAC_CS = 1'b1;
    wait_clk(3);
    chk_zero("midrst");
    RESET = 1'b1;
    e_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLOCK);
      e_cnt += int'(FRAME_ERROR) + int'(FRAME_VALID);
    end
    chk("midrst_no_pulse", 64'(e_cnt), 64'd0);
  endtask

  task automatic apply(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    xfer(v.word, v.nbits, v.clr);
    chk({t, "_valid_pulses"}, 64'(v_cnt), 64'(v.exp_valid ? 1 : 0));
    chk({t, "_error_pulses"}, 64'(e_cnt), 64'(v.exp_valid ? 0 : 1));
    chk({t, "_last_cmd"}, 64'(LAST_CMD), 64'(v.exp_cmd));
    chk({t, "_last_addr"}, 64'(LAST_ADDR), 64'(v.exp_addr));
    chk({t, "_outs"}, 64'({OUT_A, OUT_B, OUT_C, OUT_D}),
        64'(v.exp_out));
    if (v.chk_echo)
      chk({t, "_echo"}, 64'(miso_word), 64'(v.exp_echo));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    miso_word = '0;

    vecs[0]  = '{32'h000F5550, 32, 1'b0, 1'b1, 4'h0, 4'hF,
                 {12'h000, 12'h000, 12'h000, 12'h000},
                 1'b1, 32'h00000000};
    vecs[1]  = '{32'h00110000, 32, 1'b0, 1'b1, 4'h1, 4'h1,
                 {12'h000, 12'h555, 12'h000, 12'h000},
                 1'b1, 32'h000F5550};
    vecs[2]  = '{32'h0032ABC0, 32, 1'b0, 1'b1, 4'h3, 4'h2,
                 {12'h000, 12'h555, 12'hABC, 12'h000},
                 1'b1, 32'h00110000};
    vecs[3]  = '{32'h0032ABC0, 32, 1'b0, 1'b1, 4'h3, 4'h2,
                 {12'h000, 12'h000, 12'hABC, 12'h000},
                 1'b1, 32'h00000000};
    vecs[4]  = '{32'h00F00000, 32, 1'b0, 1'b1, 4'hF, 4'h0,
                 {12'h000, 12'h000, 12'hABC, 12'h000},
                 1'b1, 32'h0032ABC0};
    vecs[5]  = '{32'h00200120, 31, 1'b0, 1'b0, 4'hF, 4'h0,
                 {12'h000, 12'h000, 12'hABC, 12'h000},
                 1'b0, 32'h00000000};
    vecs[6]  = '{32'h00200120, 33, 1'b0, 1'b0, 4'hF, 4'h0,
                 {12'h000, 12'h000, 12'hABC, 12'h000},
                 1'b0, 32'h00000000};
    vecs[7]  = '{32'h000F5550, 32, 1'b0, 1'b1, 4'h0, 4'hF,
                 {12'h000, 12'h000, 12'hABC, 12'h000},
                 1'b0, 32'h00000000};
    vecs[8]  = '{32'h00223450, 32, 1'b0, 1'b1, 4'h2, 4'h2,
                 {12'h555, 12'h555, 12'h345, 12'h555},
                 1'b1, 32'h000F5550};
    vecs[9]  = '{32'h00371230, 32, 1'b0, 1'b1, 4'h3, 4'h7,
                 {12'h555, 12'h555, 12'h345, 12'h555},
                 1'b1, 32'h00223450};
    vecs[10] = '{32'h0030FFF0, 32, 1'b1, 1'b1, 4'h3, 4'h0,
                 {12'h000, 12'h000, 12'h000, 12'h000},
                 1'b1, 32'h00371230};
    vecs[11] = '{32'h00100000, 32, 1'b0, 1'b1, 4'h1, 4'h0,
                 {12'h000, 12'h000, 12'h000, 12'h000},
                 1'b1, 32'h0030FFF0};

    RESET           = 1'b0;
    spi_if.SPI_SCK  = 1'b0;
    spi_if.SPI_MOSI = 1'b0;
    spi_if.DAC_CS   = 1'b1;
    spi_if.DAC_CLR  = 1'b1;
    wait_clk(5);
    chk_zero("reset");
    RESET = 1'b1;
    wait_clk(4);

    for (int v = 0; v < 12; v++) begin
      if (v == 3) mid_reset();
      apply(v, vecs[v]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ltc2624_spi_responder.md
Name: ltc2624_spi_responder

Overview:
Synthesizable SPI slave model of the LTC2624 quad 12-bit DAC, i.e. the far end of the DAC SPI link driven by the dac_adapter master. It oversamples SPI_SCK, SPI_MOSI and DAC_CS in the CLOCK domain, decodes 32-bit command frames and maintains four input/output channel register pairs. It echoes the previous frame on SPI_MISO. It serves as a loopback target for on-board self-test and as a bench responder for the adapter.

Parameters:
FRAME_BITS, 32, bits per valid frame
DATA_BITS, 12, DAC data width per channel
SYNC_STAGES, 2, synchronizer flops on SPI_SCK/SPI_MOSI/DAC_CS/DAC_CLR

Ports:
CLOCK  input  1  system clock; must be >= 8x SPI_SCK frequency
RESET  input  1  asynchronous, active-low reset
SPI_SCK  input  1  SPI clock from master, idle low
SPI_MOSI  input  1  serial data from master, sampled on SCK rising edge
SPI_MISO  output  1  serial echo to master, changes on SCK falling edge
DAC_CS  input  1  active-low chip select; frame delimiter
DAC_CLR  input  1  active-low clear of all channel registers
OUT_A, OUT_B, OUT_C, OUT_D  output  12 each  DAC output registers
FRAME_VALID  output  1  one-cycle pulse: well-formed frame committed
FRAME_ERROR  output  1  one-cycle pulse: CS released with bit count != 32
LAST_CMD  output  4  command nibble of last valid frame
LAST_ADDR  output  4  address nibble of last valid frame

Behaviour:
- Reset (RESET=0, async): shift reg, bit count, all input regs, OUT_A..D, LAST_CMD, LAST_ADDR <= 0; SPI_MISO=0; FRAME_VALID=FRAME_ERROR=0. Reset mid-frame aborts the frame with no error pulse.
- Inputs pass through SYNC_STAGES flops; edges are detected on the last stage against one delay flop. Latency from pin edge to action: SYNC_STAGES+1 cycles.
- States: IDLE (CS high), SHIFT (CS low), COMMIT (1 cycle).
- IDLE -> SHIFT on CS falling: bit count <= 0; SPI_MISO <= sr[31].
- SHIFT, SCK rising: sr <= {sr[30:0], MOSI}; count <= count+1, saturating at 33.
- SHIFT, SCK falling: SPI_MISO <= sr[31]. The master therefore receives the previous frame's 32 bits, MSB first.
- SHIFT -> COMMIT on CS rising. SCK edges in IDLE are ignored.
- COMMIT: if count==32, decode and pulse FRAME_VALID; otherwise pulse FRAME_ERROR and change no register. Return to IDLE. SPI_MISO driven 0 while in IDLE.
- Frame layout, MSB first: [31:24] don't care, [23:20] CMD, [19:16] ADDR, [15:4] DATA, [3:0] don't care.
- ADDR decode: 0..3 selects A..D; 4'hF selects all; any other ADDR selects none, but FRAME_VALID still pulses and LAST_* still update.
- CMD 0000: write input reg(s) of the selected channel(s).
- CMD 0001: copy input reg to OUT for the selected channel(s).
- CMD 0010: write input reg(s), then update all four OUTs from input regs, including the new value.
- CMD 0011: write and update the selected channel(s).
- CMD 1111 and any other CMD: no-op on registers; LAST_* still update.
- OUT and input regs change in the COMMIT cycle; new values are visible the following cycle.
- DAC_CLR (synchronized) low: all input regs and OUTs <= 0 every cycle it is held low. The frame in progress continues shifting.
- DAC_CLR low in the COMMIT cycle: clear wins and the frame's register writes are dropped. FRAME_VALID and LAST_* still update.

Decomposition:
- Shared package ltc2624_pkg: command nibble constants (CMD_WRITE, CMD_UPDATE, CMD_WRITE_UPDATE_ALL, CMD_WRITE_UPDATE, CMD_NOP), ADDR_ALL=4'hF, frame field bit positions, and the state enum.
- One sub-module: spi_edge_sync, the SYNC_STAGES synchronizer plus rise/fall detector, instantiated once per input pin.

Test Plan:
- Reset mid-frame: after 16 SCKs, assert RESET=0 -> all outputs 0, no FRAME_ERROR; the next full frame commits normally.
- Frame 0x00_3_2_ABC_0 (write+update C) -> OUT_C=12'hABC, other OUTs 0, FRAME_VALID 1 cycle, LAST_CMD=3, LAST_ADDR=2.
- Frame 0x00_0_F_555_0, then 0x00_1_1_000_0 -> only OUT_B=12'h555; A, C, D stay 0.
- Second frame after 0x00_3_2_ABC_0 -> SPI_MISO sequence over its 32 SCKs equals 0x0032ABC0, MSB first.
- CS released after 31 bits, and separately after 33 bits -> FRAME_ERROR pulse, OUTs unchanged, LAST_* unchanged.
- DAC_CLR low coincident with COMMIT of 0x00_3_0_FFF_0 -> OUT_A=0, FRAME_VALID=1, LAST_CMD=3.
